// File: rtl/timer_pkg.sv
// timer_pkg: shared register-map offsets, CTRL/STATUS bit positions and a
// half-word merge helper for the io_timer_bank timer channels.
package timer_pkg;

  // Register stride between consecutive channels on the IO bus.
  localparam int CH_STRIDE = 8;

  // Per-channel register offsets.
  typedef enum logic [2:0] {
    OFS_RELOAD_L = 3'd0,
    OFS_RELOAD_H = 3'd1,
    OFS_COUNT_L  = 3'd2,
    OFS_COUNT_H  = 3'd3,
    OFS_CTRL     = 3'd4,
    OFS_STATUS   = 3'd5,
    OFS_CAP_L    = 3'd6,
    OFS_CAP_H    = 3'd7
  } ofs_e;

  // CTRL bit positions.
  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;
  localparam int CTRL_PRESC_LSB    = 8;

  // STATUS bit positions.
  localparam int STAT_EXP_BIT = 0;
  localparam int STAT_CAP_BIT = 1;

  // Replace the low or high 16-bit half of a 32-bit register image.
  function automatic logic [31:0] merge_half(input logic [31:0] cur,
                                             input logic        hi,
                                             input logic [15:0] d);
    return hi ? {d, cur[15:0]} : {cur[31:16], d};
  endfunction

endpackage

// File: rtl/io_timer_bank_if.sv
// io_timer_bank_if: J1 IO bus signals seen by the timer bank.
// The CPU side uses the master modport, the timer bank the slave modport.
interface io_timer_bank_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] mem_addr;
  logic [15:0] dout;
  logic [15:0] io_din;

  modport master (output io_rd, io_wr, mem_addr, dout, input io_din);
  modport slave  (input io_rd, io_wr, mem_addr, dout, output io_din);
endinterface

// File: rtl/timer_channel.sv
// timer_channel: one down-counting timer with reload, prescaler, one-shot or
// periodic mode, sticky expiry flag and coherent 32-bit COUNT reads.
// Capture logic is built only when TIMER_CAPTURE_EN is defined.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        sel,      // address falls in this channel
  input  logic        rd,       // read strobe, already qualified by sel
  input  logic        wr,       // write strobe, already qualified by sel
  input  ofs_e        ofs,
  input  logic [15:0] wdata,
  input  logic        capture,
  output logic [15:0] rdata,
  output logic        irq_req
);

  localparam bit HAS_HI = (WIDTH > 16);

  logic [WIDTH-1:0]   reload_q, count_q, cap_q;
  logic [PRESC_W-1:0] div_q, presc_q;
  logic               enable_q, periodic_q, irq_en_q;
  logic               flag_exp_q, flag_cap_q;
  logic [15:0]        shadow_q;
  logic [31:0]        reload_ext, count_ext, cap_ext;

  assign reload_ext = 32'(reload_q);
  assign count_ext  = 32'(count_q);
  assign cap_ext    = 32'(cap_q);

  logic wr_reload, wr_count, wr_ctrl, clr_exp, tick, expire;

  assign wr_reload = wr && (ofs == OFS_RELOAD_L || (HAS_HI && ofs == OFS_RELOAD_H));
  assign wr_count  = wr && (ofs == OFS_COUNT_L  || (HAS_HI && ofs == OFS_COUNT_H));
  assign wr_ctrl   = wr && (ofs == OFS_CTRL);
  assign clr_exp   = wr && (ofs == OFS_STATUS) && wdata[STAT_EXP_BIT];
  // >= rather than == so a divisor lowered mid-count cannot stall the prescaler.
  assign tick      = enable_q && (presc_q >= div_q);
  // A COUNT write consumes the tick entirely, expiry included.
  assign expire    = tick && !wr_count && (count_q == '0);

  // Reload register: half-word writes, upper half absent for 16-bit timers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)        reload_q <= '0;
    else if (wr_reload) reload_q <= WIDTH'(merge_half(reload_ext, ofs == OFS_RELOAD_H, wdata));
  end

  // Prescaler: held at 0 while disabled, restarted by COUNT writes and on wrap.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)                             presc_q <= '0;
    else if (!enable_q || wr_count || tick)  presc_q <= '0;
    else                                     presc_q <= presc_q + PRESC_W'(1);
  end

  // Counter: software writes win over ticks; expiry reloads or parks at zero.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)       count_q <= '0;
    else if (wr_count) count_q <= WIDTH'(merge_half(count_ext, ofs == OFS_COUNT_H, wdata));
    else if (tick) begin
      if (count_q != '0)   count_q <= count_q - WIDTH'(1);
      else if (periodic_q) count_q <= reload_q;
    end
  end

  // Control fields; a one-shot expiry drops enable unless CTRL is written that cycle.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      enable_q   <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      div_q      <= '0;
    end else if (wr_ctrl) begin
      enable_q   <= wdata[CTRL_EN_BIT];
      periodic_q <= wdata[CTRL_PERIODIC_BIT];
      irq_en_q   <= wdata[CTRL_IRQ_EN_BIT];
      div_q      <= wdata[CTRL_PRESC_LSB +: PRESC_W];
    end else if (expire && !periodic_q) begin
      enable_q   <= 1'b0;
    end
  end

  // Sticky expiry flag: set has priority over write-1-to-clear.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)      flag_exp_q <= 1'b0;
    else if (expire)  flag_exp_q <= 1'b1;
    else if (clr_exp) flag_exp_q <= 1'b0;
  end

  // COUNT_H shadow, latched by a COUNT_L read so the pair reads coherently.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)                        shadow_q <= '0;
    else if (rd && ofs == OFS_COUNT_L)  shadow_q <= count_ext[31:16];
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0] cap_sync_q;
  logic       cap_edge, clr_cap;

  assign cap_edge = cap_sync_q[1] & ~cap_sync_q[2];
  assign clr_cap  = wr && (ofs == OFS_STATUS) && wdata[STAT_CAP_BIT];

  // Two-stage synchroniser plus one history stage for rising-edge detection.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) cap_sync_q <= '0;
    else         cap_sync_q <= {cap_sync_q[1:0], capture};
  end

  // Capture register and sticky capture flag; set wins over clear.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      cap_q      <= '0;
      flag_cap_q <= 1'b0;
    end else if (cap_edge) begin
      cap_q      <= count_q;
      flag_cap_q <= 1'b1;
    end else if (clr_cap) begin
      flag_cap_q <= 1'b0;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign cap_q          = '0;
  assign flag_cap_q     = 1'b0;
`endif

  assign irq_req = irq_en_q & (flag_exp_q | flag_cap_q);

  // Read mux, zero when the address is not in this channel.
  // NOTE: every output of an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (ofs)
        OFS_RELOAD_L: rdata = reload_ext[15:0];
        OFS_RELOAD_H: rdata = reload_ext[31:16];
        OFS_COUNT_L:  rdata = count_ext[15:0];
        OFS_COUNT_H:  rdata = shadow_q;
        OFS_CTRL: begin
          rdata[CTRL_EN_BIT]                 = enable_q;
          rdata[CTRL_PERIODIC_BIT]           = periodic_q;
          rdata[CTRL_IRQ_EN_BIT]             = irq_en_q;
          rdata[CTRL_PRESC_LSB +: PRESC_W]   = div_q;
        end
        OFS_STATUS: begin
          rdata[STAT_EXP_BIT] = flag_exp_q;
          rdata[STAT_CAP_BIT] = flag_cap_q;
        end
        OFS_CAP_L:    rdata = cap_ext[15:0];
        OFS_CAP_H:    rdata = cap_ext[31:16];
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/io_timer_bank.sv
// io_timer_bank: bank of CHANNELS down-counting timers on the J1 IO bus.
// Decodes channel/offset, ORs per-channel read data and registers the
// combined interrupt. Optional capture inputs: define TIMER_CAPTURE_EN.
module io_timer_bank
  import timer_pkg::*;
#(
  parameter int          CHANNELS  = 2,
  parameter int          WIDTH     = 32,
  parameter logic [15:0] BASE_ADDR = 16'd110,
  parameter int          PRESC_W   = 8
) (
  input  logic                clk,
  input  logic                resetq,
  io_timer_bank_if.slave      bus,
  input  logic [CHANNELS-1:0] capture,
  output logic                irq
);

  logic [15:0] rel;
  logic        in_range;
  logic [12:0] ch_idx;
  ofs_e        ofs;

  assign rel      = bus.mem_addr - BASE_ADDR;
  assign in_range = (bus.mem_addr >= BASE_ADDR) && (rel < 16'(CH_STRIDE * CHANNELS));
  assign ch_idx   = rel[15:3];
  assign ofs      = ofs_e'(rel[2:0]);

  logic [15:0]         ch_rdata [CHANNELS];
  logic [CHANNELS-1:0] ch_irq;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic sel;
    assign sel = in_range && (ch_idx == 13'(c));

    timer_channel #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) u_ch (
      .clk     (clk),
      .resetq  (resetq),
      .sel     (sel),
      .rd      (bus.io_rd && sel),
      .wr      (bus.io_wr && sel),
      .ofs     (ofs),
      .wdata   (bus.dout),
      .capture (capture[c]),
      .rdata   (ch_rdata[c]),
      .irq_req (ch_irq[c])
    );
  end

  // OR the per-channel read data; unselected channels contribute zero.
  always_comb begin
    bus.io_din = '0;
    for (int c = 0; c < CHANNELS; c++) bus.io_din = bus.io_din | ch_rdata[c];
  end

  // Registered interrupt request, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) irq <= 1'b0;
    else         irq <= |ch_irq;
  end

endmodule

// File: tb/tb_io_timer_bank.sv
// tb_io_timer_bank: self-checking bench for io_timer_bank (2 channels, 32-bit).
// Directed scenarios plus randomized timer runs checked against a closed-form
// model of count, flag and enable as a function of elapsed cycles.
module tb_io_timer_bank;
  import timer_pkg::*;

  localparam logic [15:0] BASE = 16'd110;

  logic       clk = 1'b0;
  logic       resetq = 1'b0;
  logic [1:0] capture = 2'b00;
  logic       irq;

  io_timer_bank_if bus ();

  io_timer_bank #(.CHANNELS(2), .WIDTH(32), .BASE_ADDR(BASE), .PRESC_W(8)) dut (
    .clk     (clk),
    .resetq  (resetq),
    .bus     (bus),
    .capture (capture),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] addr(input int ch, input int ofs);
    return BASE + 16'(8 * ch + ofs);
  endfunction

  // Bus helpers are called at a negedge and return at a negedge.
  task automatic wr(input int ch, input int ofs, input logic [15:0] d);
    bus.mem_addr = addr(ch, ofs);
    bus.dout     = d;
    bus.io_wr    = 1'b1;
    @(negedge clk);
    bus.io_wr    = 1'b0;
  endtask

  task automatic rd(input int ch, input int ofs, output logic [15:0] d);
    bus.mem_addr = addr(ch, ofs);
    bus.io_rd    = 1'b1;
    #1 d = bus.io_din;
    @(negedge clk);
    bus.io_rd    = 1'b0;
  endtask

  // Combinational look at io_din without a read strobe; consumes no clock edge.
  task automatic peek(input int ch, input int ofs, output logic [15:0] d);
    bus.mem_addr = addr(ch, ofs);
    #1 d = bus.io_din;
  endtask

  // Timer state t clock edges after enabling with count c0, reload r, divisor d.
  function automatic void model(input int c0, input int r, input int d, input int per,
                                input int t, output int cnt, output int flag, output int en);
    int n;
    n = t / (d + 1);
    if (n <= c0) begin
      cnt = c0 - n; flag = 0; en = 1;
    end else begin
      flag = 1;
      if (per != 0) begin cnt = r - ((n - c0 - 1) % (r + 1)); en = 1; end
      else          begin cnt = 0; en = 0; end
    end
  endfunction

  task automatic test_reset;
    logic [15:0] v;
    for (int ch = 0; ch < 2; ch++)
      for (int o = 0; o < 8; o++) begin
        peek(ch, o, v);
        total++;
        if (v !== 16'h0000) begin
          bad++; $display("FAIL reset_reg ch%0d ofs%0d: got %h expected 0000", ch, o, v);
        end
      end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_periodic;
    logic [15:0] v;
    wr(0, OFS_RELOAD_H, 16'h0000); wr(0, OFS_RELOAD_L, 16'd4);
    wr(0, OFS_COUNT_H, 16'h0000);  wr(0, OFS_COUNT_L, 16'd4);
    wr(0, OFS_CTRL, 16'h0007);
    repeat (4) @(negedge clk);
    peek(0, OFS_STATUS, v); total++;
    if (v !== 16'h0000) begin bad++; $display("FAIL periodic_flag_t4: got %h expected 0000", v); end
    @(negedge clk);
    peek(0, OFS_STATUS, v); total++;
    if (v !== 16'h0001) begin bad++; $display("FAIL periodic_flag_t5: got %h expected 0001", v); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL periodic_irq_t5: got %b expected 0", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL periodic_irq_t6: got %b expected 1", irq); end
    peek(0, OFS_COUNT_L, v); total++;
    if (v !== 16'd3) begin bad++; $display("FAIL periodic_count_t6: got %h expected 0003", v); end
    repeat (4) @(negedge clk);
    peek(0, OFS_COUNT_L, v); total++;
    if (v !== 16'd4) begin bad++; $display("FAIL periodic_reload_t10: got %h expected 0004", v); end
    wr(0, OFS_CTRL, 16'h0000); wr(0, OFS_STATUS, 16'h0003);
    @(negedge clk);
  endtask

  task automatic test_oneshot;
    logic [15:0] v;
    wr(1, OFS_COUNT_H, 16'h0000); wr(1, OFS_COUNT_L, 16'd2);
    wr(1, OFS_CTRL, 16'h0301);
    repeat (11) @(negedge clk);
    peek(1, OFS_STATUS, v); total++;
    if (v !== 16'h0000) begin bad++; $display("FAIL oneshot_flag_t11: got %h expected 0000", v); end
    @(negedge clk);
    peek(1, OFS_STATUS, v); total++;
    if (v !== 16'h0001) begin bad++; $display("FAIL oneshot_flag_t12: got %h expected 0001", v); end
    peek(1, OFS_CTRL, v); total++;
    if (v !== 16'h0300) begin bad++; $display("FAIL oneshot_ctrl_t12: got %h expected 0300", v); end
    repeat (5) @(negedge clk);
    peek(1, OFS_COUNT_L, v); total++;
    if (v !== 16'h0000) begin bad++; $display("FAIL oneshot_count_hold: got %h expected 0000", v); end
    wr(1, OFS_STATUS, 16'h0001);
    peek(1, OFS_STATUS, v); total++;
    if (v !== 16'h0000) begin bad++; $display("FAIL oneshot_clear: got %h expected 0000", v); end
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_irq: got %b expected 0", irq); end
    wr(1, OFS_CTRL, 16'h0000);
  endtask

  task automatic test_coherent;
    logic [15:0] v;
    wr(0, OFS_COUNT_H, 16'h0001); wr(0, OFS_COUNT_L, 16'h0000);
    wr(0, OFS_CTRL, 16'h0001);
    rd(0, OFS_COUNT_L, v); total++;
    if (v !== 16'h0000) begin bad++; $display("FAIL coherent_lo: got %h expected 0000", v); end
    rd(0, OFS_COUNT_H, v); total++;
    if (v !== 16'h0001) begin bad++; $display("FAIL coherent_hi: got %h expected 0001", v); end
    peek(0, OFS_COUNT_L, v); total++;
    if (v !== 16'hFFFE) begin bad++; $display("FAIL coherent_live: got %h expected fffe", v); end
    peek(0, OFS_COUNT_H, v); total++;
    if (v !== 16'h0001) begin bad++; $display("FAIL coherent_peek_hi: got %h expected 0001", v); end
    rd(0, OFS_COUNT_L, v); total++;
    if (v !== 16'hFFFE) begin bad++; $display("FAIL coherent_lo2: got %h expected fffe", v); end
    rd(0, OFS_COUNT_H, v); total++;
    if (v !== 16'h0000) begin bad++; $display("FAIL coherent_hi2: got %h expected 0000", v); end
    wr(0, OFS_CTRL, 16'h0000);
  endtask

  task automatic test_collision;
    logic [15:0] v;
    wr(0, OFS_COUNT_H, 16'h0000); wr(0, OFS_RELOAD_H, 16'h0000);
    wr(0, OFS_COUNT_L, 16'd20);   wr(0, OFS_RELOAD_L, 16'd20);
    wr(0, OFS_CTRL, 16'h0003);
    repeat (3) @(negedge clk);
    wr(0, OFS_COUNT_L, 16'h0055);
    peek(0, OFS_COUNT_L, v); total++;
    if (v !== 16'h0055) begin bad++; $display("FAIL collide_count_write: got %h expected 0055", v); end
    @(negedge clk);
    peek(0, OFS_COUNT_L, v); total++;
    if (v !== 16'h0054) begin bad++; $display("FAIL collide_count_next: got %h expected 0054", v); end
    wr(0, OFS_CTRL, 16'h0000); wr(0, OFS_STATUS, 16'h0003);
    wr(0, OFS_RELOAD_L, 16'd3); wr(0, OFS_COUNT_L, 16'd0);
    wr(0, OFS_CTRL, 16'h0003);
    wr(0, OFS_STATUS, 16'h0001);
    peek(0, OFS_STATUS, v); total++;
    if (v !== 16'h0001) begin bad++; $display("FAIL collide_set_wins: got %h expected 0001", v); end
    peek(0, OFS_COUNT_L, v); total++;
    if (v !== 16'd3) begin bad++; $display("FAIL collide_reload: got %h expected 0003", v); end
    wr(0, OFS_STATUS, 16'h0001);
    peek(0, OFS_STATUS, v); total++;
    if (v !== 16'h0000) begin bad++; $display("FAIL collide_clear: got %h expected 0000", v); end
    wr(0, OFS_CTRL, 16'h0000); wr(0, OFS_STATUS, 16'h0003);
    @(negedge clk);
  endtask

  task automatic test_fields;
    logic [15:0] v;
    wr(1, OFS_CTRL, 16'hFFF8);
    peek(1, OFS_CTRL, v); total++;
    if (v !== 16'hFF00) begin bad++; $display("FAIL ctrl_fields: got %h expected ff00", v); end
    wr(1, OFS_RELOAD_H, 16'hBEEF);
    peek(1, OFS_RELOAD_H, v); total++;
    if (v !== 16'hBEEF) begin bad++; $display("FAIL reload_hi: got %h expected beef", v); end
    wr(1, OFS_CAP_L, 16'h1234);
    peek(1, OFS_CAP_L, v); total++;
    if (v !== 16'h0000) begin bad++; $display("FAIL cap_write_ignored: got %h expected 0000", v); end
    wr(1, OFS_CTRL, 16'h0000);
  endtask

  task automatic test_unmapped;
    logic [15:0] v;
    logic [15:0] probes [4];
    probes[0] = BASE + 16'd16; probes[1] = BASE + 16'd24;
    probes[2] = BASE - 16'd1;  probes[3] = BASE - 16'd8;
    wr(0, OFS_RELOAD_L, 16'hABCD); wr(1, OFS_RELOAD_L, 16'h1234);
    peek(1, OFS_RELOAD_L, v); total++;
    if (v !== 16'h1234) begin bad++; $display("FAIL decode_ch1: got %h expected 1234", v); end
    for (int i = 0; i < 4; i++) begin
      bus.mem_addr = probes[i];
      #1 v = bus.io_din;
      total++;
      if (v !== 16'h0000) begin
        bad++; $display("FAIL unmapped_%0d addr %0d: got %h expected 0000", i, probes[i], v);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] v;
    wr(0, OFS_RELOAD_H, 16'h0000); wr(0, OFS_RELOAD_L, 16'd4);
    wr(0, OFS_COUNT_H, 16'h0000);  wr(0, OFS_COUNT_L, 16'd4);
    wr(0, OFS_CTRL, 16'h0007);
    repeat (7) @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL midreset_irq_before: got %b expected 1", irq); end
    bus.mem_addr = addr(0, OFS_STATUS);
    #2 resetq = 1'b0;
    #1;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL midreset_irq: got %b expected 0", irq); end
    total++;
    if (bus.io_din !== 16'h0000) begin
      bad++; $display("FAIL midreset_io_din: got %h expected 0000", bus.io_din);
    end
    @(negedge clk);
    resetq = 1'b1;
    @(negedge clk);
    test_reset();
  endtask

  task automatic test_capture;
    logic [15:0] v;
    wr(0, OFS_COUNT_H, 16'h0000); wr(0, OFS_COUNT_L, 16'h0123);
    capture[0] = 1'b1;
    repeat (5) @(negedge clk);
    peek(0, OFS_CAP_L, v); total++;
`ifdef TIMER_CAPTURE_EN
    if (v !== 16'h0123) begin bad++; $display("FAIL capture_value: got %h expected 0123", v); end
    peek(0, OFS_STATUS, v); total++;
    if (v !== 16'h0002) begin bad++; $display("FAIL capture_flag: got %h expected 0002", v); end
`else
    if (v !== 16'h0000) begin bad++; $display("FAIL capture_value: got %h expected 0000", v); end
    peek(0, OFS_STATUS, v); total++;
    if (v !== 16'h0000) begin bad++; $display("FAIL capture_flag: got %h expected 0000", v); end
`endif
    capture[0] = 1'b0;
    wr(0, OFS_STATUS, 16'h0003);
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [15:0] v;
    int ch, r, c0, d, per, ien, m;
    int cnt, flag, en, cnt1, flag1, en1;
    for (int it = 0; it < 16; it++) begin
      ch  = int'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 7));
      c0  = int'($urandom_range(0, 7));
      d   = int'($urandom_range(0, 3));
      per = int'($urandom_range(0, 1));
      ien = int'($urandom_range(0, 1));
      m   = int'($urandom_range(0, 40));
      wr(ch, OFS_RELOAD_H, 16'h0000); wr(ch, OFS_RELOAD_L, 16'(r));
      wr(ch, OFS_COUNT_H, 16'h0000);  wr(ch, OFS_COUNT_L, 16'(c0));
      wr(ch, OFS_CTRL, 16'((d << 8) | (ien << 2) | (per << 1) | 1));
      repeat (m) @(negedge clk);
      model(c0, r, d, per, m, cnt, flag, en);
      rd(ch, OFS_COUNT_L, v); total++;
      if (v !== 16'(cnt)) begin
        bad++; $display("FAIL rand%0d_count ch%0d r=%0d c=%0d d=%0d p=%0d t=%0d: got %h expected %h",
                        it, ch, r, c0, d, per, m, v, 16'(cnt));
      end
      total++;
      if (irq !== 1'(ien & flag)) begin
        bad++; $display("FAIL rand%0d_irq: got %b expected %b", it, irq, 1'(ien & flag));
      end
      model(c0, r, d, per, m + 1, cnt1, flag1, en1);
      peek(ch, OFS_STATUS, v); total++;
      if (v !== 16'(flag1)) begin
        bad++; $display("FAIL rand%0d_status: got %h expected %h", it, v, 16'(flag1));
      end
      peek(ch, OFS_CTRL, v); total++;
      if (v !== 16'((d << 8) | (ien << 2) | (per << 1) | en1)) begin
        bad++; $display("FAIL rand%0d_ctrl: got %h expected %h", it, v,
                        16'((d << 8) | (ien << 2) | (per << 1) | en1));
      end
      wr(ch, OFS_CTRL, 16'h0000); wr(ch, OFS_STATUS, 16'h0003);
      @(negedge clk);
    end
  endtask

  initial begin
    bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.mem_addr = '0; bus.dout = '0;
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    @(negedge clk);
    test_reset();
    test_periodic();
    test_oneshot();
    test_coherent();
    test_collision();
    test_fields();
    test_capture();
    test_random();
    test_unmapped();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
